// File: rtl/eth_pkg.sv
// Shared Ethernet transmit-path definitions.
// Holds the FSM state encodings, CRC-32 constants and the preamble/SFD
// nibble values used by the FCS appender and the companion RX checker.
package eth_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PAD      = 3'd3;
  localparam logic [2:0] ST_FCS      = 3'd4;
  localparam logic [2:0] ST_IFG      = 3'd5;

  // Ethernet CRC-32, bit-reflected form
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  // Frame delimiters as seen on the nibble stream
  localparam logic [3:0] SFD_NIBBLE = 4'hD;
  localparam logic [3:0] PRE_NIBBLE = 4'h5;

endpackage

// File: rtl/eth_crc32_nibble.sv
// Combinational single-nibble CRC-32 update.
// Folds one nibble into a running reflected CRC-32, bit 0 of the nibble
// first, matching the LSB-first transmission order of MII.
// Ports:
//   crc      - current CRC register value
//   nibble   - nibble to fold in
//   crc_next - CRC after the four bit iterations
module eth_crc32_nibble
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 4; i++) begin
      if (crc_next[0] ^ nibble[i]) begin
        crc_next = (crc_next >> 1) ^ CRC32_POLY_REFL;
      end else begin
        crc_next = crc_next >> 1;
      end
    end
  end

endmodule

// File: rtl/eth_fcs_appender.sv
// Ethernet FCS appender.
// Forwards the preamble/SFD/data nibble stream to the MII transmit pins
// with one cycle of latency, recomputes the CRC-32 over the post-SFD data,
// zero-pads short frames, appends the FCS and enforces the inter-frame gap.
// Ports:
//   nibble_clk - transmit nibble clock
//   rstn       - synchronous active-low reset
//   in_d       - input nibble, low nibble of each byte first
//   in_valid   - input frame envelope
//   tx_d       - MII transmit nibble
//   tx_en      - MII transmit enable
//   frame_done - one-cycle pulse with the last FCS nibble
//   busy       - high whenever the FSM is not idle
//   drop_cnt   - saturating count of dropped or aborted frames
module eth_fcs_appender
  import eth_pkg::*;
#(
  parameter int MIN_DATA_NIBBLES = 120,
  parameter int IFG_NIBBLES      = 24,
  parameter int MAX_PRE_NIBBLES  = 16
) (
  input  logic       nibble_clk,
  input  logic       rstn,
  input  logic [3:0] in_d,
  input  logic       in_valid,
  output logic [3:0] tx_d,
  output logic       tx_en,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int PRE_W = $clog2(MAX_PRE_NIBBLES + 2);
  localparam int IFG_W = $clog2(IFG_NIBBLES + 1);
  localparam logic [PRE_W-1:0] PRE_LIMIT    = PRE_W'(MAX_PRE_NIBBLES);
  localparam logic [IFG_W-1:0] IFG_LAST     = IFG_W'(IFG_NIBBLES - 1);
  localparam logic [11:0]      MIN_P1       = 12'(MIN_DATA_NIBBLES + 1);
  localparam logic [10:0]      DATA_CNT_MAX = 11'd2047;

  logic [2:0]       state, state_nxt;
  logic [31:0]      crc, crc_nxt, crc_upd, fcs_word;
  logic [3:0]       crc_nibble, tx_d_nxt;
  logic [10:0]      data_cnt, data_cnt_nxt, data_cnt_inc;
  logic [11:0]      data_cnt_p1;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
  logic [IFG_W-1:0] ifg_cnt, ifg_cnt_nxt;
  logic [2:0]       fcs_idx, fcs_idx_nxt;
  logic             tx_en_nxt, done_nxt, drop_inc, pad_needed, tail;
  logic             in_valid_q, in_valid_rise;

  // Pad nibbles are folded into the CRC as zeros.
  assign crc_nibble = (state == ST_DATA && in_valid) ? in_d : 4'h0;

  eth_crc32_nibble u_crc (
    .crc      (crc),
    .nibble   (crc_nibble),
    .crc_next (crc_upd)
  );

  assign fcs_word      = ~crc;
  assign in_valid_rise = in_valid & ~in_valid_q;
  assign data_cnt_inc  = (data_cnt == DATA_CNT_MAX) ? data_cnt : data_cnt + 11'd1;
  // data_cnt < MIN written as data_cnt+1 < MIN+1 so it stays a real
  // comparison even when padding is disabled (MIN = 0).
  assign data_cnt_p1   = {1'b0, data_cnt} + 12'd1;
  assign pad_needed    = data_cnt_p1 < MIN_P1;

  always_comb begin
    state_nxt    = state;
    tx_d_nxt     = 4'h0;
    tx_en_nxt    = 1'b0;
    done_nxt     = 1'b0;
    crc_nxt      = crc;
    data_cnt_nxt = data_cnt;
    pre_cnt_nxt  = pre_cnt;
    ifg_cnt_nxt  = ifg_cnt;
    fcs_idx_nxt  = fcs_idx;
    drop_inc     = 1'b0;
    tail         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt   = ST_PREAMBLE;
          tx_d_nxt    = in_d;
          tx_en_nxt   = 1'b1;
          pre_cnt_nxt = PRE_W'(1);
        end
      end

      ST_PREAMBLE: begin
        // Abort on a runt or on one preamble nibble too many; the rest of
        // an overlong frame is swallowed in IFG without a second count.
        if (!in_valid || (in_d != SFD_NIBBLE && pre_cnt >= PRE_LIMIT)) begin
          state_nxt   = ST_IFG;
          ifg_cnt_nxt = '0;
          drop_inc    = 1'b1;
        end else begin
          tx_d_nxt  = in_d;
          tx_en_nxt = 1'b1;
          if (in_d == SFD_NIBBLE) begin
            state_nxt    = ST_DATA;
            crc_nxt      = CRC32_INIT;
            data_cnt_nxt = '0;
          end else begin
            pre_cnt_nxt = pre_cnt + PRE_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (in_valid) begin
          tx_d_nxt     = in_d;
          tx_en_nxt    = 1'b1;
          crc_nxt      = crc_upd;
          data_cnt_nxt = data_cnt_inc;
        end else begin
          tail = 1'b1;
        end
      end

      ST_PAD: tail = 1'b1;

      ST_FCS: begin
        tx_d_nxt    = fcs_word[{fcs_idx, 2'b00} +: 4];
        tx_en_nxt   = 1'b1;
        fcs_idx_nxt = fcs_idx + 3'd1;
        if (fcs_idx == 3'd7) begin
          done_nxt    = 1'b1;
          state_nxt   = ST_IFG;
          ifg_cnt_nxt = '0;
        end
      end

      ST_IFG: begin
        // Hold here while a dropped frame is still arriving so it is never
        // picked up half way through.
        if (ifg_cnt == IFG_LAST) begin
          if (!in_valid) state_nxt = ST_IDLE;
        end else begin
          ifg_cnt_nxt = ifg_cnt + IFG_W'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // The nibble after the last data nibble: either the next pad nibble or
    // the first FCS nibble, so tx_en never gaps between data and FCS.
    if (tail) begin
      tx_en_nxt = 1'b1;
      if (pad_needed) begin
        state_nxt    = ST_PAD;
        tx_d_nxt     = 4'h0;
        crc_nxt      = crc_upd;
        data_cnt_nxt = data_cnt_inc;
      end else begin
        state_nxt   = ST_FCS;
        tx_d_nxt    = fcs_word[3:0];
        fcs_idx_nxt = 3'd1;
      end
    end

    if ((state == ST_PAD || state == ST_FCS || state == ST_IFG) && in_valid_rise) begin
      drop_inc = 1'b1;
    end
  end

  always_ff @(posedge nibble_clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      crc        <= CRC32_INIT;
      data_cnt   <= '0;
      pre_cnt    <= '0;
      ifg_cnt    <= '0;
      fcs_idx    <= '0;
      in_valid_q <= 1'b0;
      tx_d       <= 4'h0;
      tx_en      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      state      <= state_nxt;
      crc        <= crc_nxt;
      data_cnt   <= data_cnt_nxt;
      pre_cnt    <= pre_cnt_nxt;
      ifg_cnt    <= ifg_cnt_nxt;
      fcs_idx    <= fcs_idx_nxt;
      in_valid_q <= in_valid;
      tx_d       <= tx_d_nxt;
      tx_en      <= tx_en_nxt;
      frame_done <= done_nxt;
      busy       <= (state_nxt != ST_IDLE);
      if (drop_inc && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_fcs_appender.sv
// Directed testbench for eth_fcs_appender.
// One instance uses the standard 60-byte minimum; a second instance with
// padding disabled checks the raw CRC of "123456789".
module tb_eth_fcs_appender;
  import eth_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] in_d, in_d0;
  logic       in_valid, in_valid0;
  logic [3:0] tx_d, tx_d0;
  logic       tx_en, tx_en0, frame_done, frame_done0, busy, busy0;
  logic [7:0] drop_cnt, drop_cnt0;

  always #5 clk = ~clk;

  eth_fcs_appender #(.MIN_DATA_NIBBLES(120), .IFG_NIBBLES(24), .MAX_PRE_NIBBLES(16)) dut (
    .nibble_clk(clk), .rstn(rstn), .in_d(in_d), .in_valid(in_valid),
    .tx_d(tx_d), .tx_en(tx_en), .frame_done(frame_done), .busy(busy), .drop_cnt(drop_cnt)
  );

  eth_fcs_appender #(.MIN_DATA_NIBBLES(0), .IFG_NIBBLES(24), .MAX_PRE_NIBBLES(16)) dut0 (
    .nibble_clk(clk), .rstn(rstn), .in_d(in_d0), .in_valid(in_valid0),
    .tx_d(tx_d0), .tx_en(tx_en0), .frame_done(frame_done0), .busy(busy0), .drop_cnt(drop_cnt0)
  );

  int          passed = 0;
  int          total  = 0;
  logic        use0   = 1'b0;
  logic [3:0]  cap[$];
  logic [3:0]  exp_q[$];
  int          done_pulses;
  int          en_rises;
  logic        prev_en;
  logic        timed_out;

  // Sample the selected DUT at the falling edge, then drive its next input.
  task automatic tick(input logic [3:0] d, input logic v);
    logic en, dn;
    logic [3:0] q;
    @(negedge clk);
    en = use0 ? tx_en0 : tx_en;
    q  = use0 ? tx_d0 : tx_d;
    dn = use0 ? frame_done0 : frame_done;
    if (en) cap.push_back(q);
    if (dn) done_pulses++;
    if (en && !prev_en) en_rises++;
    prev_en = en;
    if (use0) begin in_d0 = d; in_valid0 = v; end
    else begin in_d = d; in_valid = v; end
  endtask

  task automatic clear_capture();
    cap.delete();
    done_pulses = 0;
    en_rises    = 0;
    prev_en     = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] data[$]);
    for (int i = 0; i < 15; i++) tick(PRE_NIBBLE, 1'b1);
    tick(SFD_NIBBLE, 1'b1);
    foreach (data[i]) tick(data[i], 1'b1);
  endtask

  // Idle the input until the transmit burst has started and ended.
  task automatic drain(input int max_cycles);
    int n = 0;
    tick(4'h0, 1'b0);
    while ((prev_en || en_rises == 0) && n < max_cycles) begin
      tick(4'h0, 1'b0);
      n++;
    end
    timed_out = (n >= max_cycles);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((use0 ? busy0 : busy) && n < max_cycles) begin
      tick(4'h0, 1'b0);
      n++;
    end
    timed_out = (n >= max_cycles);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    rstn = 1'b1;
    tick(4'h0, 1'b0);
  endtask

  // Expected wire image: preamble, SFD, data, zero pad, FCS. The CRC is
  // computed a byte at a time over the padded payload.
  task automatic build_exp(input logic [3:0] data[$], input int min_nib);
    logic [3:0]  d[$];
    logic [31:0] c;
    logic [7:0]  b;
    d = data;
    while (d.size() < min_nib) d.push_back(4'h0);
    c = 32'hFFFFFFFF;
    for (int i = 0; i + 1 < d.size(); i += 2) begin
      b = {d[i+1], d[i]};
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    foreach (d[i]) exp_q.push_back(d[i]);
    for (int k = 0; k < 8; k++) exp_q.push_back(c[4*k +: 4]);
  endtask

  task automatic make_ascii(output logic [3:0] data[$]);
    string s;
    byte   ch;
    s = "123456789";
    data.delete();
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      data.push_back(ch[3:0]);
      data.push_back(ch[7:4]);
    end
  endtask

  function automatic int count_diffs();
    int bad = 0;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      if (cap[i] !== exp_q[i]) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_d = 4'h0; in_valid0 = 1'b0; in_d0 = 4'h0;
    clear_capture();
    repeat (3) tick(4'h0, 1'b0);
    total++; if (tx_d !== 4'h0) $display("[TB] FAIL reset_tx_d: got %0h, expected 0", tx_d); else passed++;
    total++; if (tx_en !== 1'b0) $display("[TB] FAIL reset_tx_en: got %0b, expected 0", tx_en); else passed++;
    total++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_done: got %0b, expected 0", frame_done); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); else passed++;
    total++; if (drop_cnt !== 8'd0) $display("[TB] FAIL reset_drop: got %0d, expected 0", drop_cnt); else passed++;
    rstn = 1'b1;
    tick(4'h0, 1'b0);
  endtask

  task automatic test_basic_crc();
    logic [3:0] data[$];
    int bad;
    make_ascii(data);
    use0 = 1'b0;
    clear_capture();
    send_frame(data);
    drain(300);
    build_exp(data, 120);
    bad = count_diffs();
    total++; if (timed_out) $display("[TB] FAIL basic_timeout: got timeout, expected tx_en burst end"); else passed++;
    total++; if (cap.size() != 144) $display("[TB] FAIL basic_len: got %0d, expected 144", cap.size()); else passed++;
    total++; if (bad != 0) $display("[TB] FAIL basic_content: got %0d wrong nibbles, expected 0", bad); else passed++;
    total++; if (done_pulses != 1) $display("[TB] FAIL basic_done: got %0d pulses, expected 1", done_pulses); else passed++;
    total++; if (en_rises != 1) $display("[TB] FAIL basic_continuous: got %0d tx_en bursts, expected 1", en_rises); else passed++;
    wait_idle(100);
  endtask

  task automatic test_unpadded_crc();
    logic [3:0]  data[$];
    logic [31:0] obs;
    make_ascii(data);
    use0 = 1'b1;
    clear_capture();
    send_frame(data);
    drain(300);
    obs = 32'hx;
    if (cap.size() >= 8) begin
      for (int k = 0; k < 8; k++) obs[4*k +: 4] = cap[cap.size() - 8 + k];
    end
    total++; if (cap.size() != 42) $display("[TB] FAIL raw_len: got %0d, expected 42", cap.size()); else passed++;
    total++; if (obs !== 32'hCBF43926) $display("[TB] FAIL raw_fcs: got %08h, expected cbf43926", obs); else passed++;
    total++; if (done_pulses != 1) $display("[TB] FAIL raw_done: got %0d pulses, expected 1", done_pulses); else passed++;
    total++; if (en_rises != 1) $display("[TB] FAIL raw_continuous: got %0d tx_en bursts, expected 1", en_rises); else passed++;
    total++; if (drop_cnt0 !== 8'd0) $display("[TB] FAIL raw_drop: got %0d, expected 0", drop_cnt0); else passed++;
    wait_idle(100);
    use0 = 1'b0;
  endtask

  task automatic test_padding();
    logic [3:0] data[$];
    int zeros = 0;
    int bad;
    for (int i = 0; i < 20; i++) data.push_back(4'((i * 7 + 3) & 15));
    clear_capture();
    send_frame(data);
    drain(300);
    build_exp(data, 120);
    bad = count_diffs();
    if (cap.size() >= 136) begin
      for (int i = 36; i < 136; i++) if (cap[i] === 4'h0) zeros++;
    end
    total++; if (cap.size() != 144) $display("[TB] FAIL pad_len: got %0d, expected 144", cap.size()); else passed++;
    total++; if (zeros != 100) $display("[TB] FAIL pad_zeros: got %0d, expected 100", zeros); else passed++;
    total++; if (bad != 0) $display("[TB] FAIL pad_content: got %0d wrong nibbles, expected 0", bad); else passed++;
    total++; if (en_rises != 1) $display("[TB] FAIL pad_continuous: got %0d tx_en bursts, expected 1", en_rises); else passed++;
    wait_idle(100);
  endtask

  task automatic test_ifg();
    logic [3:0] data[$];
    int bad;
    for (int i = 0; i < 20; i++) data.push_back(4'((i * 5 + 1) & 15));
    clear_capture();
    send_frame(data);
    drain(300);
    repeat (4) tick(4'h0, 1'b0);
    clear_capture();
    send_frame(data);
    repeat (3) tick(4'h0, 1'b0);
    total++; if (en_rises != 0) $display("[TB] FAIL ifg_blocked: got %0d tx_en bursts, expected 0", en_rises); else passed++;
    total++; if (done_pulses != 0) $display("[TB] FAIL ifg_no_done: got %0d pulses, expected 0", done_pulses); else passed++;
    total++; if (drop_cnt !== 8'd1) $display("[TB] FAIL ifg_drop: got %0d, expected 1", drop_cnt); else passed++;
    wait_idle(100);
    total++; if (busy !== 1'b0) $display("[TB] FAIL ifg_return_idle: got busy %0b, expected 0", busy); else passed++;
    repeat (25) tick(4'h0, 1'b0);
    clear_capture();
    send_frame(data);
    drain(300);
    build_exp(data, 120);
    bad = count_diffs();
    total++; if (cap.size() != 144 || bad != 0) $display("[TB] FAIL ifg_next_frame: got %0d nibbles %0d wrong, expected 144 nibbles 0 wrong", cap.size(), bad); else passed++;
    total++; if (drop_cnt !== 8'd1) $display("[TB] FAIL ifg_drop_hold: got %0d, expected 1", drop_cnt); else passed++;
    wait_idle(100);
  endtask

  task automatic test_runt();
    int busy_cycles;
    pulse_reset();
    clear_capture();
    repeat (6) tick(PRE_NIBBLE, 1'b1);
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    total++; if (cap.size() != 6) $display("[TB] FAIL runt_forwarded: got %0d nibbles, expected 6", cap.size()); else passed++;
    total++; if (tx_en !== 1'b0) $display("[TB] FAIL runt_tx_en: got %0b, expected 0", tx_en); else passed++;
    total++; if (drop_cnt !== 8'd1) $display("[TB] FAIL runt_drop: got %0d, expected 1", drop_cnt); else passed++;
    busy_cycles = 0;
    for (int n = 0; n < 60; n++) begin
      if (!busy) break;
      busy_cycles++;
      tick(4'h0, 1'b0);
    end
    total++; if (busy_cycles != 24) $display("[TB] FAIL runt_busy: got %0d cycles, expected 24", busy_cycles); else passed++;
    total++; if (done_pulses != 0) $display("[TB] FAIL runt_no_done: got %0d pulses, expected 0", done_pulses); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] data[$];
    int bad;
    clear_capture();
    for (int i = 0; i < 15; i++) tick(PRE_NIBBLE, 1'b1);
    tick(SFD_NIBBLE, 1'b1);
    for (int i = 1; i < 40; i++) tick(4'(i & 15), 1'b1);
    tick(4'hA, 1'b1);
    rstn = 1'b0;
    tick(4'h0, 1'b0);
    total++; if (tx_en !== 1'b0) $display("[TB] FAIL rst_mid_tx_en: got %0b, expected 0", tx_en); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %0b, expected 0", busy); else passed++;
    total++; if (drop_cnt !== 8'd0) $display("[TB] FAIL rst_mid_drop: got %0d, expected 0", drop_cnt); else passed++;
    tick(4'h0, 1'b0);
    rstn = 1'b1;
    repeat (3) tick(4'h0, 1'b0);
    total++; if (done_pulses != 0) $display("[TB] FAIL rst_mid_no_fcs: got %0d pulses, expected 0", done_pulses); else passed++;
    for (int i = 0; i < 80; i++) data.push_back(4'((i * 11 + 6) & 15));
    clear_capture();
    send_frame(data);
    drain(300);
    build_exp(data, 120);
    bad = count_diffs();
    total++; if (cap.size() != 144 || bad != 0) $display("[TB] FAIL rst_mid_fresh: got %0d nibbles %0d wrong, expected 144 nibbles 0 wrong", cap.size(), bad); else passed++;
    total++; if (done_pulses != 1) $display("[TB] FAIL rst_mid_fresh_done: got %0d pulses, expected 1", done_pulses); else passed++;
    wait_idle(100);
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int f = 0; f < 100; f++) begin
      tick(PRE_NIBBLE, 1'b1); tick(PRE_NIBBLE, 1'b1);
      tick(4'h0, 1'b0); tick(4'h0, 1'b0);
    end
    tick(4'h0, 1'b0);
    total++; if (drop_cnt !== 8'd100) $display("[TB] FAIL sat_count: got %0d, expected 100", drop_cnt); else passed++;
    for (int f = 0; f < 200; f++) begin
      tick(PRE_NIBBLE, 1'b1); tick(PRE_NIBBLE, 1'b1);
      tick(4'h0, 1'b0); tick(4'h0, 1'b0);
    end
    tick(4'h0, 1'b0);
    total++; if (drop_cnt !== 8'd255) $display("[TB] FAIL sat_hold: got %0d, expected 255", drop_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_crc();
    test_unpadded_crc();
    test_padding();
    test_ifg();
    test_runt();
    test_reset_mid_frame();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
